// File: rtl/cpu_run_pkg.sv
// Shared state encoding and mailbox/config address offsets for the CPU run controller.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  localparam logic [31:0] RES_ATTEMPT_OFS = 32'h0;
  localparam logic [31:0] RES_BROKEN_OFS  = 32'h4;
  localparam logic [31:0] RES_LAST_OFS    = 32'h8;
  localparam logic [31:0] RES_HALT_OFS    = 32'hC;
  localparam logic [31:0] CFG_RES_OFS     = 32'h4;

endpackage

// File: rtl/cpu_run_watchdog.sv
// RUN-cycle watchdog: saturating counter, one-cycle expired on the edge the count reaches the limit.
module cpu_run_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // The edge that moves the count onto LIMIT is the expiry edge.
  assign expired = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Preloads egg-drop operands, releases the CPU, snoops mailbox stores and re-halts it.
// Optional watchdog/TIMEOUT state compiled in with CPU_RUN_WATCHDOG_EN.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter logic [31:0] CFG_BASE       = 32'h0000_0100,
  parameter logic [31:0] RES_BASE       = 32'h0000_0200,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_start,
  input  logic [6:0]  in_floors_data,
  input  logic [6:0]  in_resistance_data,
  input  logic        cpu_mem_we,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  output logic        cpu_rst_n,
  output logic        cfg_we,
  output logic [31:0] cfg_addr,
  output logic [31:0] cfg_wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result_attempt_count,
  output logic [31:0] result_broken_count,
  output logic        result_is_last_broken
);

  state_e      state_q, state_d;
  logic [31:0] floors_q, floors_d, resist_q, resist_d;
  logic        cfg_we_q, cfg_we_d;
  logic [31:0] cfg_addr_q, cfg_addr_d, cfg_wdata_q, cfg_wdata_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic [31:0] att_q, att_d, brk_q, brk_d;
  logic        last_q, last_d;

  logic start_ok, in_run, st_att, st_brk, st_last, st_halt, wd_expired;

  assign start_ok = in_start && (state_q inside {ST_IDLE, ST_DONE, ST_TIMEOUT});
  assign in_run   = (state_q == ST_RUN);
  assign st_att   = in_run && cpu_mem_we && (cpu_mem_addr == RES_BASE + RES_ATTEMPT_OFS);
  assign st_brk   = in_run && cpu_mem_we && (cpu_mem_addr == RES_BASE + RES_BROKEN_OFS);
  assign st_last  = in_run && cpu_mem_we && (cpu_mem_addr == RES_BASE + RES_LAST_OFS);
  assign st_halt  = in_run && cpu_mem_we && (cpu_mem_addr == RES_BASE + RES_HALT_OFS)
                    && (cpu_mem_wdata != 32'h0);

`ifdef CPU_RUN_WATCHDOG_EN
  cpu_run_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (in_clk),
    .rst_n  (in_rst_n),
    .clear  (!in_run),
    .enable (in_run),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: if (start_ok) state_d = ST_LOAD0;
      ST_LOAD0:                     state_d = ST_LOAD1;
      ST_LOAD1:                     state_d = ST_RUN;
      // Halt beats a watchdog expiry on the same edge.
      ST_RUN: begin
        if (st_halt)         state_d = ST_DONE;
        else if (wd_expired) state_d = ST_TIMEOUT;
      end
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = state_q inside {ST_LOAD0, ST_LOAD1, ST_RUN};
    done        = (state_q == ST_DONE);
`ifdef CPU_RUN_WATCHDOG_EN
    timeout     = (state_q == ST_TIMEOUT);
`else
    timeout     = 1'b0;
`endif
    cfg_we_d    = 1'b0;
    cfg_addr_d  = 32'h0;
    cfg_wdata_d = 32'h0;
    if (state_d == ST_LOAD0) begin
      cfg_we_d    = 1'b1;
      cfg_addr_d  = CFG_BASE;
      cfg_wdata_d = floors_d;
    end else if (state_d == ST_LOAD1) begin
      cfg_we_d    = 1'b1;
      cfg_addr_d  = CFG_BASE + CFG_RES_OFS;
      cfg_wdata_d = resist_d;
    end
    // Release only after a full cycle in RUN, so both preload writes have landed.
    cpu_rst_n_d = in_run && (state_d == ST_RUN);
  end

  always_comb begin
    floors_d = start_ok ? {25'h0, in_floors_data}     : floors_q;
    resist_d = start_ok ? {25'h0, in_resistance_data} : resist_q;
    att_d    = att_q;
    brk_d    = brk_q;
    last_d   = last_q;
    if (start_ok) begin
      att_d  = 32'h0;
      brk_d  = 32'h0;
      last_d = 1'b0;
    end else begin
      if (st_att)  att_d  = cpu_mem_wdata;
      if (st_brk)  brk_d  = cpu_mem_wdata;
      if (st_last) last_d = cpu_mem_wdata[0];
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      floors_q    <= 32'h0;
      resist_q    <= 32'h0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= 32'h0;
      cfg_wdata_q <= 32'h0;
      cpu_rst_n_q <= 1'b0;
      att_q       <= 32'h0;
      brk_q       <= 32'h0;
      last_q      <= 1'b0;
    end else begin
      floors_q    <= floors_d;
      resist_q    <= resist_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      att_q       <= att_d;
      brk_q       <= brk_d;
      last_q      <= last_d;
    end
  end

  assign cpu_rst_n             = cpu_rst_n_q;
  assign cfg_we                = cfg_we_q;
  assign cfg_addr              = cfg_addr_q;
  assign cfg_wdata             = cfg_wdata_q;
  assign result_attempt_count  = att_q;
  assign result_broken_count   = brk_q;
  assign result_is_last_broken = last_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized scoreboard bench for cpu_run_ctrl: preload writes and run completions are
// predicted from a behavioural mailbox model and checked by an independent monitor.
module tb_cpu_run_ctrl;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [6:0]  in_floors_data = '0;
  logic [6:0]  in_resistance_data = '0;
  logic        cpu_mem_we = 1'b0;
  logic [31:0] cpu_mem_addr = '0;
  logic [31:0] cpu_mem_wdata = '0;
  logic        cpu_rst_n, cfg_we, busy, done, timeout, result_is_last_broken;
  logic [31:0] cfg_addr, cfg_wdata, result_attempt_count, result_broken_count;

  localparam int TMO = 16;
`ifdef CPU_RUN_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  cpu_run_ctrl #(
    .CFG_BASE(32'h0000_0100),
    .RES_BASE(32'h0000_0200),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start),
    .in_floors_data(in_floors_data), .in_resistance_data(in_resistance_data),
    .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_rst_n(cpu_rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .timeout(timeout),
    .result_attempt_count(result_attempt_count), .result_broken_count(result_broken_count),
    .result_is_last_broken(result_is_last_broken)
  );

  always #5 in_clk = ~in_clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } cfg_t;
  typedef struct packed { logic is_to; logic [31:0] att; logic [31:0] brk; logic last; } end_t;
  typedef struct packed {
    logic st; logic we; logic [31:0] a; logic [31:0] d; logic [6:0] fl; logic [6:0] rs;
  } op_t;

  cfg_t cfg_exp[$];
  end_t end_exp[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_att = '0, m_brk = '0;
  logic        m_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes predicted preload writes and run completions as the DUT presents them.
  logic fin_prev = 1'b0;
  always @(negedge in_clk) begin
    if (!in_rst_n) begin
      fin_prev <= 1'b0;
    end else begin
      if (cfg_we) begin
        if (cfg_exp.size() == 0) begin
          chk("cfg_unexpected_write", 32'(cfg_we), 32'h0);
        end else begin
          cfg_t c;
          c = cfg_exp.pop_front();
          chk("cfg_addr", cfg_addr, c.addr);
          chk("cfg_wdata", cfg_wdata, c.data);
        end
      end else begin
        chk("cfg_addr_idle", cfg_addr, 32'h0);
        chk("cfg_wdata_idle", cfg_wdata, 32'h0);
      end
      if ((done || timeout) && !fin_prev) begin
        if (end_exp.size() == 0) begin
          chk("end_unexpected", 32'(done || timeout), 32'h0);
        end else begin
          end_t x;
          x = end_exp.pop_front();
          chk("end_done", 32'(done), 32'(!x.is_to));
          chk("end_timeout", 32'(timeout), 32'(x.is_to));
          chk("end_attempt", result_attempt_count, x.att);
          chk("end_broken", result_broken_count, x.brk);
          chk("end_last", 32'(result_is_last_broken), 32'(x.last));
          chk("end_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
          chk("end_busy", 32'(busy), 32'h0);
        end
      end
      fin_prev <= done || timeout;
    end
  end

  // Inputs change on the falling edge and are sampled on the next rising edge.
  task automatic apply(input op_t o, input bit model_run);
    @(negedge in_clk);
    in_start      = o.st;
    cpu_mem_we    = o.we;
    cpu_mem_addr  = o.a;
    cpu_mem_wdata = o.d;
    if (o.st) begin
      in_floors_data     = o.fl;
      in_resistance_data = o.rs;
    end
    if (model_run && o.we) begin
      case (o.a)
        32'h200: m_att  = o.d;
        32'h204: m_brk  = o.d;
        32'h208: m_last = o.d[0];
        default: ;
      endcase
    end
  endtask

  // Any RUN-phase event except a nonzero halt store.
  function automatic op_t rand_op();
    op_t o;
    logic [31:0] others [5];
    others = '{32'h300, 32'h210, 32'h1FC, 32'h100, 32'h20D};
    o = '0;
    case ($urandom_range(0, 6))
      0: begin o.we = 1'b1; o.a = 32'h200; o.d = $urandom; end
      1: begin o.we = 1'b1; o.a = 32'h204; o.d = $urandom; end
      2: begin o.we = 1'b1; o.a = 32'h208; o.d = $urandom; end
      3: begin o.we = 1'b1; o.a = 32'h20C; o.d = 32'h0; end
      4: begin o.we = 1'b1; o.a = others[$urandom_range(0, 4)]; o.d = $urandom; end
      5: begin o.st = 1'b1; o.fl = 7'($urandom); o.rs = 7'($urandom); end
      default: begin o.we = 1'b0; o.a = 32'h20C; o.d = 32'h1; end
    endcase
    return o;
  endfunction

  function automatic op_t dir_op(input int i);
    op_t o;
    o = '0;
    case (i)
      0: begin o.we = 1'b1; o.a = 32'h200; o.d = 32'd6; end
      1: begin o.we = 1'b1; o.a = 32'h204; o.d = 32'd1; end
      2: begin o.we = 1'b1; o.a = 32'h208; o.d = 32'd3; end
      3: begin o.st = 1'b1; o.fl = 7'd99; o.rs = 7'd77; end
      4: begin o.we = 1'b1; o.a = 32'h20C; o.d = 32'd0; end
      default: begin o.we = 1'b1; o.a = 32'h300; o.d = 32'd123; end
    endcase
    return o;
  endfunction

  // Start pulse plus the two preload cycles; leaves the DUT in its first RUN cycle.
  task automatic start_seq(input logic [6:0] fl, input logic [6:0] rs);
    op_t o;
    cfg_exp.push_back({32'h100, 25'd0, fl});
    cfg_exp.push_back({32'h104, 25'd0, rs});
    o = '0; o.st = 1'b1; o.fl = fl; o.rs = rs;
    apply(o, 1'b0);
    m_att = '0; m_brk = '0; m_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      o = '0; o.st = 1'b1; o.we = 1'b1; o.a = (i == 0) ? 32'h200 : 32'h20C;
      o.d = 32'h5A5A_0001; o.fl = 7'($urandom); o.rs = 7'($urandom);
      apply(o, 1'b0);
      chk("load_busy", 32'(busy), 32'h1);
      chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
      chk("load_attempt_cleared", result_attempt_count, 32'h0);
      chk("load_broken_cleared", result_broken_count, 32'h0);
      chk("load_last_cleared", 32'(result_is_last_broken), 32'h0);
    end
  endtask

  // mode 0: halt early; 1: no halt (timeout when the watchdog exists); 2: halt on expiry edge.
  task automatic run(input logic [6:0] fl, input logic [6:0] rs, input int mode, input bit directed);
    op_t o;
    int  e, n, limit;
    bit  exp_to;
    start_seq(fl, rs);
    e = 1;  // RUN-relative edge at which the next applied op is sampled
    n = directed ? 6 : $urandom_range(2, 10);
    for (int i = 0; i < n; i++) begin
      o = directed ? dir_op(i) : rand_op();
      apply(o, 1'b1);
      chk("run_busy", 32'(busy), 32'h1);
      chk("run_cpu_rst_n", 32'(cpu_rst_n), 32'(e >= 2));
      e++;
    end
    limit = WD_EN ? TMO : 20;
    if (mode != 0) begin
      while (e < limit) begin
        o = rand_op();
        apply(o, 1'b1);
        chk("run_busy_long", 32'(busy), 32'h1);
        e++;
      end
    end
    exp_to = WD_EN && (mode == 1);
    o = '0;
    if (!exp_to) begin
      o.we = 1'b1; o.a = 32'h20C; o.d = directed ? 32'd1 : ($urandom | 32'h1);
    end
    end_exp.push_back({exp_to, m_att, m_brk, m_last});
    apply(o, 1'b1);
    chk("pre_end_busy", 32'(busy), 32'h1);
    chk("pre_end_timeout", 32'(timeout), 32'h0);
    o = '0; o.we = 1'b1; o.a = 32'h200; o.d = 32'hFFFF;
    apply(o, 1'b1 && 1'b0);
    chk("post_done", 32'(done), 32'(!exp_to));
    chk("post_timeout", 32'(timeout), 32'(exp_to));
    chk("post_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    o = '0;
    apply(o, 1'b0);
    chk("hold_attempt", result_attempt_count, m_att);
    chk("hold_broken", result_broken_count, m_brk);
    chk("hold_last", 32'(result_is_last_broken), 32'(m_last));
    chk("hold_done", 32'(done), 32'(!exp_to));
  endtask

  task automatic reset_mid_run();
    op_t o;
    start_seq(7'd33, 7'd11);
    o = '0; o.we = 1'b1; o.a = 32'h200; o.d = 32'd7; apply(o, 1'b1);
    o.a = 32'h204; o.d = 32'd9; apply(o, 1'b1);
    o.a = 32'h208; o.d = 32'd1; apply(o, 1'b1);
    o = '0; apply(o, 1'b0);
    chk("pre_reset_attempt", result_attempt_count, 32'd7);
    #2 in_rst_n = 1'b0;
    #1;
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_cfg_we", 32'(cfg_we), 32'h0);
    chk("rst_attempt", result_attempt_count, 32'h0);
    chk("rst_broken", result_broken_count, 32'h0);
    chk("rst_last", 32'(result_is_last_broken), 32'h0);
    m_att = '0; m_brk = '0; m_last = 1'b0;
    @(negedge in_clk);
    #2 in_rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("init_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_done", 32'(done), 32'h0);
    chk("init_timeout", 32'(timeout), 32'h0);
    chk("init_cfg_we", 32'(cfg_we), 32'h0);
    chk("init_attempt", result_attempt_count, 32'h0);
    @(negedge in_clk);
    #2 in_rst_n = 1'b1;

    run(7'd40, 7'd20, 0, 1'b1);
    run(7'd10, 7'd5, 0, 1'b0);
    run(7'd25, 7'd3, 1, 1'b0);
    run(7'd25, 7'd3, 2, 1'b0);
    run(7'd1, 7'd127, 0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      run(7'($urandom), 7'($urandom), $urandom_range(0, 2), 1'b0);
    end
    reset_mid_run();
    run(7'd64, 7'd8, 0, 1'b0);

    repeat (3) @(negedge in_clk);
    chk("cfg_queue_drained", 32'(cfg_exp.size()), 32'h0);
    chk("end_queue_drained", 32'(end_exp.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the pipelined MIPS core in `board_top`. It latches the egg-drop problem inputs (`in_floors_data`, `in_resistance_data`) and preloads them into data memory while the CPU is held in reset. It then releases the CPU, snoops CPU data-memory stores to capture the results, and re-halts the CPU on completion or on watchdog expiry. This makes each run repeatable without toggling the board reset.

## Interface
- `CFG_BASE`, default 32'h0000_0100: data-memory address for floors; resistance is written at `CFG_BASE+4`.
- `RES_BASE`, default 32'h0000_0200: result mailbox.
  - `+0` attempt count.
  - `+4` broken count.
  - `+8` last-broken (bit 0).
  - `+C` halt flag.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit, in cycles spent in RUN.
- `in_clk` input 1: single clock; every register is clocked on its rising edge.
- `in_rst_n` input 1: reset, asynchronous, active-low.
- `in_start` input 1: one-cycle start request.
- `in_floors_data` input 7: floors operand.
- `in_resistance_data` input 7: resistance operand.
- `cpu_mem_we` input 1: CPU data-memory store strobe.
- `cpu_mem_addr` input 32: CPU store address.
- `cpu_mem_wdata` input 32: CPU store data.
- `cpu_rst_n` output 1: active-low reset driven to the CPU core.
- `cfg_we` output 1: preload write strobe to the data-memory second port.
- `cfg_addr` output 32: preload address.
- `cfg_wdata` output 32: preload data.
- `busy` output 1: high in LOAD0, LOAD1 and RUN.
- `done` output 1: high in DONE.
- `timeout` output 1: high in TIMEOUT.
- `result_attempt_count` output 32: captured attempt count.
- `result_broken_count` output 32: captured broken count.
- `result_is_last_broken` output 1: captured last-broken flag.

## Operation
- States:
  - IDLE
  - LOAD0
  - LOAD1
  - RUN
  - DONE
  - TIMEOUT
- IDLE/DONE/TIMEOUT with `in_start=1` → LOAD0.
  - Operands are latched, zero-extended to 32 bits.
  - All result outputs are cleared.
- `in_start` is ignored in LOAD0, LOAD1 and RUN.
- LOAD0: `cfg_we=1`, `cfg_addr=CFG_BASE`, `cfg_wdata=floors` → LOAD1.
- LOAD1: `cfg_we=1`, `cfg_addr=CFG_BASE+4`, `cfg_wdata=resistance` → RUN.
- RUN:
  - `cpu_rst_n=1`; the watchdog counts from 0.
  - Stores with `cpu_mem_we=1` whose address matches a mailbox word update the matching result register.
    - `+8` captures bit 0 only.
  - A store to `+C` with nonzero data → DONE.
  - A store to `+C` with zero data is ignored.
  - Non-matching addresses are ignored.
  - Stores outside RUN are ignored.
- DONE and TIMEOUT hold `cpu_rst_n=0`; results are held until the next start.
- `cpu_rst_n=0` in every state except RUN.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including `cpu_rst_n`.
- Reset asserted mid-run: the block returns to IDLE immediately and asynchronously; the CPU is re-held in reset.

## Timing
- Start accepted at edge N:
  - LOAD0 writes during cycle N+1.
  - LOAD1 writes during cycle N+2.
  - `cpu_rst_n` rises at edge N+3.
- Halt store sampled at edge M: `done=1` and `cpu_rst_n=0` from edge M. This is registered, so it is visible in the cycle after the store.
- Watchdog: TIMEOUT is entered at the edge where the RUN cycle count reaches `TIMEOUT_CYCLES`.
- A halt store on the same edge as expiry → DONE; halt wins.
- `cfg_*` outputs are registered.
- `cfg_addr` and `cfg_wdata` are 0 whenever `cfg_we=0`.

## Configuration
- `CPU_RUN_WATCHDOG_EN` defined:
  - The watchdog counter and TIMEOUT state are compiled in.
  - The counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates.
- `CPU_RUN_WATCHDOG_EN` undefined:
  - There is no counter; RUN waits indefinitely for the halt store.
  - `timeout` is tied to 0.
  - TIMEOUT is unreachable.

## Structure
- Package `cpu_run_pkg`:
  - State enum.
  - Mailbox offset constants (`RES_ATTEMPT_OFS`, `RES_BROKEN_OFS`, `RES_LAST_OFS`, `RES_HALT_OFS`, `CFG_RES_OFS`).
- Sub-module `cpu_run_watchdog`:
  - Inputs: `clear` and `enable`.
  - Output: one-cycle `expired`.
  - Instantiated only under the macro.

## Test plan
- Reset: `in_rst_n=0` mid-run → IDLE immediately; `cpu_rst_n=0`, `busy=0`, `done=0`, all results 0.
- Start sequence: `in_start` pulse with floors=40, resistance=20 → preload writes (0x100,40) then (0x104,20) on consecutive cycles; `cpu_rst_n=1` on the third edge; `busy=1` throughout.
- Results: stores 0x200←6, 0x204←1, 0x208←3, then 0x20C←1 → `done=1` next cycle, `attempt=6`, `broken=1`, `last_broken=1`, `cpu_rst_n=0`.
- Watchdog: with `TIMEOUT_CYCLES=16` and no halt → `timeout=1` exactly 16 edges after RUN entry; a halt store on the expiry edge gives `done=1`, `timeout=0`.
- Ignored events: start during RUN → no change; store to 0x20C←0 → stays in RUN; store to 0x300 → results unchanged.
- Restart from DONE: `in_start` → results cleared, preload repeats with the new operands (10, 5).
